// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the pipelined multiply-accumulate unit.
package mac_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} mac_state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_K      = 4;

   // Full product width plus enough guard bits that K terms can never overflow.
   function automatic int acc_width(input int data_w, input int k);
      return 2 * data_w + $clog2(k) + 1;
   endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// First pipeline stage: full-precision signed product registered every cycle.
module mac_mult_stage #(
   parameter int DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [DATA_W-1:0]   a_in,
   input  logic signed [DATA_W-1:0]   b_in,
   output logic signed [2*DATA_W-1:0] prod_p1
);

   localparam int P_W = 2 * DATA_W;

   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;

   assign a_ext = P_W'(a_in);
   assign b_ext = P_W'(b_in);

   // stage 0 -> stage 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prod_p1 <= '0;
      else     prod_p1 <= a_ext * b_ext;
   end

endmodule

// File: rtl/mac_unit.sv
// K-term signed dot-product engine: product stage followed by a count/state accumulator.
// Define MAC_ASSERT_EN to compile in simulation-only consistency checks.
module mac_unit
   import mac_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int K      = DEF_K,
   localparam int ACC_W  = acc_width(DATA_W, K)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic signed [DATA_W-1:0] b_in,
   input  logic                     acc_clear,
   output logic                     acc_out_valid,
   output logic signed [ACC_W-1:0]  acc_out
);

   localparam int P_W   = 2 * DATA_W;
   localparam int CNT_W = $clog2(K + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   logic signed [P_W-1:0] prod_p1;
   logic [CNT_W-1:0]      count;
   mac_state_t            state;

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [P_W-1:0] p);
      return ACC_W'(p);
   endfunction

   mac_mult_stage #(.DATA_W(DATA_W)) u_mult (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .prod_p1 (prod_p1)
   );

   // stage 1 -> stage 2: acc_clear is aligned with the product already in prod_p1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         acc_out       <= '0;
         acc_out_valid <= 1'b0;
      end else if (acc_clear) begin
         acc_out <= sext(prod_p1);
         count   <= CNT_ONE;
         if (K == 1) begin
            state         <= DONE;
            acc_out_valid <= 1'b1;
         end else begin
            state         <= ACCUM;
            acc_out_valid <= 1'b0;
         end
      end else begin
         case (state)
            ACCUM: begin
               acc_out <= acc_out + sext(prod_p1);
               count   <= count + CNT_ONE;
               if (count == CNT_LAST) begin
                  state         <= DONE;
                  acc_out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MAC_ASSERT_EN
   logic                   hold_chk;
   logic signed [ACC_W-1:0] acc_hold;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_chk <= 1'b0;
         acc_hold <= '0;
      end else begin
         hold_chk <= (state == DONE) && !acc_clear;
         acc_hold <= acc_out;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (acc_out_valid && (count != CNT_W'(K)))
            $error("mac_unit: acc_out_valid with count=%0d", count);
         if ($isunknown(acc_clear))
            $error("mac_unit: acc_clear is X/Z");
         if (hold_chk && (acc_out != acc_hold))
            $error("mac_unit: acc_out changed while DONE");
      end
   end
`endif

endmodule

// File: tb/tb_mac_unit.sv
// Directed-vector bench for mac_unit with hand-computed dot products.
module tb_mac_unit;

   localparam int DATA_W = 16;
   localparam int K      = 4;
   localparam int ACC_W  = 2 * DATA_W + $clog2(K) + 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic signed [DATA_W-1:0] a_in = '0;
   logic signed [DATA_W-1:0] b_in = '0;
   logic                     acc_clear = 1'b0;
   logic                     acc_out_valid;
   logic signed [ACC_W-1:0]  acc_out;

   int n_checks = 0;
   int n_pass   = 0;

   mac_unit #(.DATA_W(DATA_W), .K(K)) dut (
      .clk           (clk),
      .rst           (rst),
      .a_in          (a_in),
      .b_in          (b_in),
      .acc_clear     (acc_clear),
      .acc_out_valid (acc_out_valid),
      .acc_out       (acc_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Present one operand pair, clock it in, then settle 1 time unit past the edge.
   task automatic step(input int a, input int b, input logic clr);
      a_in      = DATA_W'(a);
      b_in      = DATA_W'(b);
      acc_clear = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1. reset
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_acc", acc_out, 0);
      check_val("rst_vld", acc_out_valid, 0);
      rst = 1'b0;
      step(7, 9, 0);
      step(3, 3, 0);
      step(5, 5, 0);
      check_val("idle_acc", acc_out, 0);
      check_val("idle_vld", acc_out_valid, 0);

      // 2. [1 2 3 4].[5 6 7 8] = 70
      step(1, 5, 0);
      step(2, 6, 1);
      check_val("t2_first", acc_out, 5);
      step(3, 7, 0);
      step(4, 8, 0);
      check_val("t2_vld_early", acc_out_valid, 0);
      step(0, 0, 0);
      check_val("t2_acc", acc_out, 70);
      check_val("t2_vld", acc_out_valid, 1);

      // 3. [-1 10 -20 3].[2 -3 4 5] = -97, seeded during the hold cycle of test 2
      step(-1, 2, 0);
      check_val("t2_hold_acc", acc_out, 70);
      check_val("t2_hold_vld", acc_out_valid, 1);
      step(10, -3, 1);
      check_val("t3_clr_vld", acc_out_valid, 0);
      check_val("t3_clr_acc", acc_out, -2);
      step(-20, 4, 0);
      step(3, 5, 0);
      step(0, 0, 0);
      check_val("t3_acc", acc_out, -97);
      check_val("t3_vld", acc_out_valid, 1);
      step(11, 11, 0);
      check_val("t3_hold_acc", acc_out, -97);
      check_val("t3_hold_vld", acc_out_valid, 1);

      // 4. extremes
      step(-32768, -32768, 0);
      step(-32768, -32768, 1);
      step(-32768, -32768, 0);
      step(-32768, -32768, 0);
      step(0, 0, 0);
      check_val("t4_acc", acc_out, 64'sd4294967296);
      check_val("t4_vld", acc_out_valid, 1);

      // 5. restart mid-sum: 1 + 4, then clear to 9 + 16 + 25 + 36 = 86
      step(1, 1, 0);
      step(2, 2, 1);
      step(3, 3, 0);
      check_val("t5_part", acc_out, 5);
      step(4, 4, 1);
      check_val("t5_restart", acc_out, 9);
      step(5, 5, 0);
      step(6, 6, 0);
      check_val("t5_vld_early", acc_out_valid, 0);
      step(0, 0, 0);
      check_val("t5_acc", acc_out, 86);
      check_val("t5_vld", acc_out_valid, 1);

      // 6. async reset during ACCUM, then a clean sequence
      step(1, 5, 0);
      step(2, 6, 1);
      step(3, 7, 0);
      #2 rst = 1'b1;
      #1;
      check_val("t6_rst_acc", acc_out, 0);
      check_val("t6_rst_vld", acc_out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 5, 0);
      step(2, 6, 1);
      step(3, 7, 0);
      step(4, 8, 0);
      step(0, 0, 0);
      check_val("t6_acc", acc_out, 70);
      check_val("t6_vld", acc_out_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
